rs_pulse_driver: RTL and testbench
==================================

Name: rs_pulse_driver

Overview:
Clocked transmitter that generates the set (S) and reset (R) edge pulses consumed by the edge-triggered RS latch in each photonic switch channel. It accepts a requested switch level over a valid/ready handshake and emits exactly one S or R pulse of programmable width. After each pulse it enforces a hold-off interval for switch settling. It sits between the switch-control register file and the per-switch latch, one instance per channel.

Parameters:
PULSE_W, 4, pulse high time in clk cycles; legal range >= 1
HOLDOFF_W, 16, dead time after pulse falls, in clk cycles; 0 returns directly to IDLE
REFRESH_PERIOD, 1024, idle cycles between refresh pulses; used only with RS_REFRESH_EN
CNT_W, 11, timer width; must hold max(PULSE_W, HOLDOFF_W, REFRESH_PERIOD)

Ports:
clk  in  1  system clock
reset  in  1  reset, asynchronous, active-high
cmd_valid  in  1  requested-level command valid
cmd_state  in  1  requested switch level, 1=set, 0=reset
cmd_force  in  1  emit a pulse even when cmd_state equals cur_state
cmd_ready  out  1  driver can accept a command (IDLE only)
s_pulse  out  1  set pulse to latch S input, registered
r_pulse  out  1  reset pulse to latch R input, registered
cur_state  out  1  last level driven to the latch
busy  out  1  high in INIT, PULSE, HOLDOFF
done  out  1  one-cycle strobe on HOLDOFF→IDLE (or PULSE→IDLE when HOLDOFF_W=0)

Behaviour:
- Reset (async): s_pulse=0, r_pulse=0, cur_state=0, cmd_ready=0, busy=1, done=0, FSM=INIT, timer=PULSE_W. Outputs drop immediately, even mid-pulse.
- States: INIT, IDLE, PULSE, HOLDOFF.
- INIT: on the first clk edge after reset deasserts, r_pulse rises for PULSE_W cycles; this forces the latch to a known 0. Then HOLDOFF, then IDLE. cur_state stays 0.
- IDLE: cmd_ready=1, busy=0. Accept on clk edge with cmd_valid & cmd_ready.
- Accepted command with cmd_state != cur_state or cmd_force=1: go to PULSE. At the next edge s_pulse (cmd_state=1) or r_pulse (cmd_state=0) rises, and cur_state updates at that same edge. The pulse lasts exactly PULSE_W cycles.
- Accepted command with cmd_state == cur_state and cmd_force=0: consumed with no pulse and no done; stays IDLE.
- Latency: 1 cycle from acceptance edge to pulse high. cmd_ready returns PULSE_W+HOLDOFF_W+1 cycles after acceptance.
- HOLDOFF: both pulses 0 for HOLDOFF_W cycles. done asserts in the cycle IDLE is re-entered.
- Invariant: s_pulse & r_pulse never both 1, including across back-to-back commands. There is at least HOLDOFF_W low cycles between any two pulses.
- Commands presented while cmd_ready=0 are not accepted; the sender must hold cmd_valid.
- Timer: a single loadable down-counter that reloads on every state entry. Terminal count is 1, so there is no wrap.

Optional Feature:
RS_REFRESH_EN
- Defined: an idle counter loads REFRESH_PERIOD on IDLE entry and decrements each IDLE cycle. At 0 it starts a PULSE matching cur_state, without changing cur_state or raising done.
- Priority: a command accepted in the same cycle as expiry wins, and the refresh counter reloads.
- Not defined: no refresh logic, REFRESH_PERIOD is unused, and IDLE holds indefinitely.

Decomposition:
- Package rs_pulse_pkg: FSM state enum (INIT, IDLE, PULSE, HOLDOFF), pulse-type enum (PULSE_NONE, PULSE_S, PULSE_R), default timing constants.
- Sub-module rs_pulse_timer: loadable CNT_W down-counter with load, enable and expire outputs. It is instantiated once, and a second time for refresh under RS_REFRESH_EN.

Test Plan:
- PULSE_W=4, HOLDOFF_W=8, release reset → r_pulse high cycles 1–4, cmd_ready=1 at cycle 13, cur_state=0, done pulses once.
- IDLE, cmd_state=1 accepted at cycle T → s_pulse high T+1..T+4, cur_state=1 from T+1, cmd_ready=1 at T+13, r_pulse never high.
- cur_state=1, cmd_state=1, cmd_force=0 → no pulse, no done, cmd_ready stays 1. Repeat with cmd_force=1 → 4-cycle s_pulse.
- cmd_valid held with alternating 0/1 commands → alternating r/s pulses each 4 cycles, ≥8 low cycles between them, never overlapping.
- Assert reset in the 2nd cycle of an s_pulse → s_pulse=0 same cycle (async), cur_state=0, INIT r_pulse after release.
- RS_REFRESH_EN, REFRESH_PERIOD=32, cur_state=1, idle → s_pulse every 32+4+8 cycles. A command in the expiry cycle overrides the refresh.

Source files
------------

// File: rtl/rs_pulse_pkg.sv
// Shared types and default timing for the RS latch pulse driver.
// The optional idle refresh is enabled with the RS_REFRESH_EN macro (see rs_pulse_driver).
package rs_pulse_pkg;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        PULSE,
        HOLDOFF
    } state_t;

    typedef enum logic [1:0] {
        PULSE_NONE,
        PULSE_S,
        PULSE_R
    } pulse_t;

    localparam int DEF_PULSE_W        = 4;
    localparam int DEF_HOLDOFF_W      = 16;
    localparam int DEF_REFRESH_PERIOD = 1024;
    localparam int DEF_CNT_W          = 11;

endpackage

// File: rtl/rs_pulse_timer.sv
// Loadable down-counter; expire flags the last cycle of an interval (count of 1).
// Counting stops at 0, so the counter never wraps.
module rs_pulse_timer #(
    parameter int CNT_W   = 11,
    parameter int RST_VAL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= CNT_W'(RST_VAL);
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - CNT_W'(1);
    end

    assign expire = (cnt == CNT_W'(1));

endmodule

// File: rtl/rs_pulse_driver.sv
// Set/reset edge-pulse generator for one photonic switch RS latch.
// Define RS_REFRESH_EN to re-pulse the current level after REFRESH_PERIOD idle cycles.
module rs_pulse_driver
    import rs_pulse_pkg::*;
#(
    parameter int PULSE_W        = DEF_PULSE_W,
    parameter int HOLDOFF_W      = DEF_HOLDOFF_W,
    parameter int REFRESH_PERIOD = DEF_REFRESH_PERIOD,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_state,
    input  logic cmd_force,
    output logic cmd_ready,
    output logic s_pulse,
    output logic r_pulse,
    output logic cur_state,
    output logic busy,
    output logic done
);

    state_t           state, state_nx;
    pulse_t           ptype, ptype_nx;
    logic             cur_nx;
    logic             rfr_q, rfr_nx;
    logic             accept;
    logic             refresh_go;
    logic             tmr_load, tmr_en, tmr_exp;
    logic [CNT_W-1:0] tmr_val;

    assign accept = cmd_valid & cmd_ready;

    // One timer serves both PULSE and HOLDOFF; it reloads on every state change.
    assign tmr_load = (state_nx != state);
    assign tmr_en   = (state == PULSE) || (state == HOLDOFF);
    assign tmr_val  = (state_nx == HOLDOFF) ? CNT_W'(HOLDOFF_W) : CNT_W'(PULSE_W);

    rs_pulse_timer #(.CNT_W(CNT_W), .RST_VAL(PULSE_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (tmr_val),
        .expire   (tmr_exp)
    );

`ifdef RS_REFRESH_EN
    logic rf_load, rf_exp;

    // Any accepted command restarts the idle interval, so a command wins over expiry.
    assign rf_load = ((state_nx == IDLE) && (state != IDLE)) || accept;

    rs_pulse_timer #(.CNT_W(CNT_W), .RST_VAL(REFRESH_PERIOD)) u_refresh (
        .clk      (clk),
        .reset    (reset),
        .load     (rf_load),
        .en       (state == IDLE),
        .load_val (CNT_W'(REFRESH_PERIOD)),
        .expire   (rf_exp)
    );

    assign refresh_go = (state == IDLE) && rf_exp && !accept;
`else
    logic unused_refresh;
    assign unused_refresh = ^CNT_W'(REFRESH_PERIOD);
    assign refresh_go     = 1'b0;
`endif

    // State register and the registered latch-facing outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT;
            ptype     <= PULSE_NONE;
            rfr_q     <= 1'b0;
            cur_state <= 1'b0;
            s_pulse   <= 1'b0;
            r_pulse   <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            ptype     <= ptype_nx;
            rfr_q     <= rfr_nx;
            cur_state <= cur_nx;
            s_pulse   <= (state_nx == PULSE) && (ptype_nx == PULSE_S);
            r_pulse   <= (state_nx == PULSE) && (ptype_nx == PULSE_R);
            done      <= (state_nx == IDLE) && ((state == PULSE) || (state == HOLDOFF)) && !rfr_q;
        end
    end

    always_comb begin
        state_nx = state;
        ptype_nx = ptype;
        cur_nx   = cur_state;
        rfr_nx   = rfr_q;
        case (state)
            INIT: begin
                // Drive the latch to a known 0 before accepting commands.
                state_nx = PULSE;
                ptype_nx = PULSE_R;
                cur_nx   = 1'b0;
                rfr_nx   = 1'b0;
            end
            IDLE: begin
                if (accept && (cmd_state != cur_state || cmd_force)) begin
                    state_nx = PULSE;
                    ptype_nx = cmd_state ? PULSE_S : PULSE_R;
                    cur_nx   = cmd_state;
                    rfr_nx   = 1'b0;
                end else if (refresh_go) begin
                    state_nx = PULSE;
                    ptype_nx = cur_state ? PULSE_S : PULSE_R;
                    rfr_nx   = 1'b1;
                end
            end
            PULSE: begin
                if (tmr_exp) begin
                    state_nx = (HOLDOFF_W == 0) ? IDLE : HOLDOFF;
                    ptype_nx = PULSE_NONE;
                end
            end
            HOLDOFF: begin
                if (tmr_exp)
                    state_nx = IDLE;
            end
            default: state_nx = INIT;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        busy      = 1'b1;
        if (state == IDLE) begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
        end
    end

endmodule

// File: tb/tb_rs_pulse_driver.sv
// Directed bench for rs_pulse_driver with PULSE_W=4, HOLDOFF_W=8, REFRESH_PERIOD=32.
// The refresh section runs only when RS_REFRESH_EN is defined.
module tb_rs_pulse_driver;

    logic clk, reset;
    logic cmd_valid, cmd_state, cmd_force;
    logic cmd_ready, s_pulse, r_pulse, cur_state, busy, done;

    int checks = 0;
    int errors = 0;

    rs_pulse_driver #(
        .PULSE_W        (4),
        .HOLDOFF_W      (8),
        .REFRESH_PERIOD (32),
        .CNT_W          (11)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_state (cmd_state),
        .cmd_force (cmd_force),
        .cmd_ready (cmd_ready),
        .s_pulse   (s_pulse),
        .r_pulse   (r_pulse),
        .cur_state (cur_state),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The first step is the acceptance edge; c counts cycles after it.
    task automatic pulse_window(input logic exp_s, input logic exp_cur);
        for (int c = 1; c <= 14; c++) begin
            step();
            if (c == 1) cmd_valid = 1'b0;
            chk("win_s",     s_pulse,   exp_s && c <= 4);
            chk("win_r",     r_pulse,   !exp_s && c <= 4);
            chk("win_ready", cmd_ready, c >= 13);
            chk("win_done",  done,      c == 13);
            chk("win_cur",   cur_state, exp_cur);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            checks++;
            assert (!(s_pulse && r_pulse)) else begin
                errors++;
                $error("FAIL overlap: observed s=%b r=%b expected not both", s_pulse, r_pulse);
            end
        end
    end

    initial begin
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_state = 1'b0;
        cmd_force = 1'b0;
        #3;
        chk("rst_s",     s_pulse,   1'b0);
        chk("rst_r",     r_pulse,   1'b0);
        chk("rst_cur",   cur_state, 1'b0);
        chk("rst_ready", cmd_ready, 1'b0);
        chk("rst_busy",  busy,      1'b1);
        chk("rst_done",  done,      1'b0);
        @(negedge clk);
        reset = 1'b0;

        // INIT: r_pulse cycles 1-4, ready and done at cycle 13.
        pulse_window(1'b0, 1'b0);

        // Set command.
        cmd_valid = 1'b1; cmd_state = 1'b1;
        pulse_window(1'b1, 1'b1);

        // Same level without force is consumed silently.
        cmd_valid = 1'b1; cmd_state = 1'b1; cmd_force = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            step();
            if (c == 1) cmd_valid = 1'b0;
            chk("noop_s",     s_pulse,   1'b0);
            chk("noop_r",     r_pulse,   1'b0);
            chk("noop_done",  done,      1'b0);
            chk("noop_ready", cmd_ready, 1'b1);
            chk("noop_cur",   cur_state, 1'b1);
        end

        // Same level with force pulses again.
        cmd_valid = 1'b1; cmd_force = 1'b1;
        pulse_window(1'b1, 1'b1);
        cmd_force = 1'b0;

        // Held valid, alternating levels: second accept is sampled in cycle 13.
        cmd_valid = 1'b1; cmd_state = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            step();
            if (c == 1) cmd_state = 1'b1;
            chk("alt_r",     r_pulse,   c <= 4);
            chk("alt_s",     s_pulse,   c >= 14 && c <= 17);
            chk("alt_ready", cmd_ready, c == 13 || c >= 26);
            chk("alt_done",  done,      c == 13 || c == 26);
            chk("alt_cur",   cur_state, c >= 14);
            if (c == 26) cmd_valid = 1'b0;
        end

        // Reset in the second cycle of an s_pulse.
        cmd_valid = 1'b1; cmd_state = 1'b1; cmd_force = 1'b1;
        step();
        cmd_valid = 1'b0; cmd_force = 1'b0;
        step();
        chk("mid_s_high", s_pulse, 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("mid_s",     s_pulse,   1'b0);
        chk("mid_r",     r_pulse,   1'b0);
        chk("mid_cur",   cur_state, 1'b0);
        chk("mid_ready", cmd_ready, 1'b0);
        chk("mid_busy",  busy,      1'b1);
        @(negedge clk);
        reset = 1'b0;
        pulse_window(1'b0, 1'b0);

`ifdef RS_REFRESH_EN
        // IDLE from cycle 13: refresh s_pulse 45-48, next expiry cycle 88 overridden by a reset command.
        cmd_valid = 1'b1; cmd_state = 1'b1;
        pulse_window(1'b1, 1'b1);
        for (int c = 15; c <= 101; c++) begin
            step();
            if (c == 89) cmd_valid = 1'b0;
            chk("rf_s",     s_pulse,   c >= 45 && c <= 48);
            chk("rf_r",     r_pulse,   c >= 89 && c <= 92);
            chk("rf_cur",   cur_state, c < 89);
            chk("rf_done",  done,      c == 101);
            chk("rf_ready", cmd_ready, c <= 44 || (c >= 57 && c <= 88) || c >= 101);
            if (c == 88) begin
                cmd_valid = 1'b1;
                cmd_state = 1'b0;
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
